shared_dmem_arbiter: RTL and testbench

- Round-robin arbiter that shares one single-port synchronous data RAM (8-bit address, 8-bit data) between the data-memory ports of NUM_CORES processor cores in the multicore build.
- Per access it does four things in order: latches one core's request, drives the RAM for one access, waits out the RAM read latency, then returns read data with a one-cycle acknowledge.
- It sits between the cores' address/data/Mem_Ctrl outputs and the shared data RAM.

---
 rtl/shared_dmem_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_shared_dmem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shared_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// shared_dmem_arbiter
//
// Shares one single-port synchronous data RAM between the data-memory ports
// of NUM_CORES cores. Each transaction is: latch one core's request (IDLE),
// drive the RAM for one cycle (ACCESS), wait out the RAM read latency (WAIT),
// then return read data with a one-cycle acknowledge (RESP). Arbitration is
// round-robin, starting one past the most recently served core.
//
// Request handshake: a core raises req[i] (with we/addr/wdata stable) and the
// request is taken when the arbiter samples it in IDLE. From that point the
// transaction runs to completion regardless of req/we/addr/wdata; ack[i]
// pulses for exactly one cycle at the end. A core holding req high after its
// ack is treated as a fresh request.
//
// Ports:
//   CLK, RSTn       clock, asynchronous active-low reset
//   req, we         per-core request / write enable
//   addr, wdata     per-core address / write data, core i at [i*W +: W]
//   gnt, ack        one-hot grant (ACCESS..RESP) / one-cycle completion
//   rdata           read data broadcast to all cores, valid with ack
//   busy            high whenever the FSM is not IDLE
//   mem_addr, mem_din, mem_we, mem_dout   RAM interface
//   dbg_state_o     current FSM state, for observation only
// All outputs are registered.
// ---------------------------------------------------------------------------
module shared_dmem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_LAT   = 1
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic [NUM_CORES-1:0]          req,
  input  logic [NUM_CORES-1:0]          we,
  input  logic [NUM_CORES*ADDR_W-1:0]   addr,
  input  logic [NUM_CORES*DATA_W-1:0]   wdata,
  output logic [NUM_CORES-1:0]          gnt,
  output logic [NUM_CORES-1:0]          ack,
  output logic [DATA_W-1:0]             rdata,
  output logic                          busy,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_din,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_dout,
  output logic [1:0]                    dbg_state_o
);

  localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;
  logic                   we_q, we_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_CORES-1:0]   gnt_q, gnt_d;
  logic [NUM_CORES-1:0]   ack_q, ack_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]      mem_din_q, mem_din_d;
  logic                   mem_we_q, mem_we_d;
  logic                   busy_q, busy_d;

  // Round-robin pick: first requesting core scanning upward from last+1.
  logic                   win_found;
  logic [IDX_W-1:0]       win_idx;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_CORES; k++) begin
      if (!win_found && req[(int'(last_q) + k) % NUM_CORES]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'((int'(last_q) + k) % NUM_CORES);
      end
    end
  end

  // Next-state and registered-output logic. Outputs are computed for the
  // state being entered so that they are valid throughout that state.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    last_d     = last_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    gnt_d      = gnt_q;
    ack_d      = '0;
    rdata_d    = rdata_q;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    mem_we_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d    = S_ACCESS;
          idx_d      = win_idx;
          we_d       = we[win_idx];
          mem_addr_d = addr[int'(win_idx)*ADDR_W +: ADDR_W];
          mem_din_d  = wdata[int'(win_idx)*DATA_W +: DATA_W];
          mem_we_d   = we[win_idx];
          gnt_d      = NUM_CORES'(1) << win_idx;
        end
      end
      S_ACCESS: begin
        state_d = S_WAIT;
        cnt_d   = CNT_W'(MEM_LAT);
      end
      S_WAIT: begin
        // cnt_q == 1 marks the cycle in which mem_dout is valid.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_RESP;
          ack_d   = gnt_q;
          if (!we_q) begin
            rdata_d = mem_dout;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        last_d  = idx_q;
        gnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      last_q     <= IDX_W'(NUM_CORES - 1);
      we_q       <= 1'b0;
      cnt_q      <= '0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q    <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      last_q     <= last_d;
      we_q       <= we_d;
      cnt_q      <= cnt_d;
      gnt_q      <= gnt_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
    end
  end

  assign gnt         = gnt_q;
  assign ack         = ack_q;
  assign rdata       = rdata_q;
  assign busy        = busy_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_shared_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for shared_dmem_arbiter (NUM_CORES=4, 8-bit address/data,
// MEM_LAT=1). Contains a latency-accurate RAM model, a shadow memory and a
// round-robin reference model (distance from the last served core), directed
// steps followed by a randomized phase.
// ---------------------------------------------------------------------------
module tb_shared_dmem_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 8;
  localparam int ML = 1;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [N-1:0]    req;
  logic [N-1:0]    we;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [N-1:0]    gnt;
  logic [N-1:0]    ack;
  logic [DW-1:0]   rdata;
  logic            busy;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_din;
  logic            mem_we;
  logic [DW-1:0]   mem_dout;
  logic [1:0]      dbg_state;

  shared_dmem_arbiter #(
    .NUM_CORES(N), .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(ML)
  ) dut (
    .CLK(clk), .RSTn(rst_n),
    .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
    .mem_dout(mem_dout), .dbg_state_o(dbg_state)
  );

  // ---------------- RAM model ----------------
  logic [DW-1:0] ram [256];
  logic [DW-1:0] rd_pipe [ML];
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (mem_we) ram[mem_addr] <= mem_din;
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < ML; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[ML-1];

  // ---------------- scoreboard / reference model ----------------
  int            checks   = 0;
  int            failures = 0;
  logic [DW-1:0] shadow [256];
  logic [DW-1:0] exp_rdata;
  int            model_last;
  int            wait_cnt [N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Winner = requesting core closest (upward, with wrap) past the last served.
  function automatic int predict(input logic [N-1:0] r);
    int best = -1;
    int bestd = N;
    for (int c = 0; c < N; c++) begin
      int d = (c - model_last - 1 + 2*N) % N;
      if (r[c] && d < bestd) begin
        bestd = d;
        best  = c;
      end
    end
    return best;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return 8'h40 + 8'($urandom_range(0, 7));
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_core(input int c, input logic r, input logic w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    req[c]            = r;
    we[c]             = w;
    addr[c*AW +: AW]  = a;
    wdata[c*DW +: DW] = d;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    shadow[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},      gnt,      0);
    check({tag, "_ack"},      ack,      0);
    check({tag, "_rdata"},    rdata,    0);
    check({tag, "_busy"},     busy,     0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_din"},  mem_din,  0);
    check({tag, "_mem_we"},   mem_we,   0);
  endtask

  task automatic model_reset();
    model_last = N - 1;
    exp_rdata  = '0;
    for (int c = 0; c < N; c++) wait_cnt[c] = 0;
  endtask

  // Called at a negedge in an IDLE cycle with core c's request presented.
  // Walks ACCESS, WAIT, RESP and the following IDLE cycle. When scramble is
  // set, core c's inputs change right after the grant (req dropped if drop).
  task automatic expect_txn(input int c, input bit scramble, input bit drop);
    logic          ew;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    logic [N-1:0]  oh;
    ew = we[c];
    ea = addr[c*AW +: AW];
    ed = wdata[c*DW +: DW];
    oh = N'(1) << c;

    @(negedge clk);  // ACCESS
    check("gnt_access",    gnt,      oh);
    check("busy_access",   busy,     1);
    check("ack_access",    ack,      0);
    check("mem_we_access", mem_we,   ew);
    check("mem_addr",      mem_addr, ea);
    check("rdata_hold",    rdata,    exp_rdata);
    if (ew) check("mem_din", mem_din, ed);
    if (scramble)
      set_core(c, !drop, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));

    for (int i = 0; i < ML; i++) begin
      @(negedge clk);  // WAIT
      check("gnt_wait",      gnt,      oh);
      check("mem_we_wait",   mem_we,   0);
      check("mem_addr_wait", mem_addr, ea);
      check("ack_wait",      ack,      0);
    end

    @(negedge clk);  // RESP
    if (ew) shadow[ea] = ed;
    else    exp_rdata  = shadow[ea];
    check("ack_resp",    ack,    oh);
    check("gnt_resp",    gnt,    oh);
    check("mem_we_resp", mem_we, 0);
    check("rdata_resp",  rdata,  exp_rdata);

    @(negedge clk);  // IDLE
    check("ack_idle",  ack,  0);
    check("gnt_idle",  gnt,  0);
    check("busy_idle", busy, 0);
    model_last = c;
  endtask

  // ---------------- invariant monitor ----------------
  always @(negedge clk) begin
    if (rst_n) begin
      check("inv_gnt_onehot", 32'($onehot0(gnt)), 1);
      check("inv_ack_onehot", 32'($onehot0(ack)), 1);
      check("inv_ack_in_gnt", 32'(ack & ~gnt),    0);
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    int w;
    rst_n = 1'b0;
    req = '0; we = '0; addr = '0; wdata = '0;
    pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    model_reset();

    // Preload RAM while the arbiter is held in reset.
    @(negedge clk);
    preload(8'h10, 8'hA5);
    preload(8'h20, 8'h00);
    for (int a = 0; a < 8; a++) preload(8'h40 + 8'(a), 8'($urandom_range(0, 255)));
    check_reset_outputs("reset");

    rst_n = 1'b1;
    @(negedge clk);
    check("idle_no_req_busy", busy, 0);
    check("idle_no_req_gnt",  gnt,  0);

    // Single read by core 1.
    set_core(1, 1'b1, 1'b0, 8'h10, 8'h00);
    expect_txn(1, 1'b0, 1'b0);
    check("single_read_rdata", rdata, 8'hA5);
    req = '0;

    // Write then read by core 2.
    set_core(2, 1'b1, 1'b1, 8'h20, 8'h3C);
    expect_txn(2, 1'b0, 1'b0);
    set_core(2, 1'b1, 1'b0, 8'h20, 8'h00);
    expect_txn(2, 1'b0, 1'b0);
    check("write_read_rdata", rdata, 8'h3C);
    req = '0;

    // Contention: all cores requesting from reset -> 0,1,2,3,0.
    rst_n = 1'b0;
    for (int c = 0; c < N; c++) set_core(c, 1'b1, 1'b0, 8'h40 + 8'(c), 8'h00);
    model_reset();
    @(negedge clk);
    check_reset_outputs("reset2");
    rst_n = 1'b1;
    expect_txn(0, 1'b0, 1'b0);
    expect_txn(1, 1'b0, 1'b0);
    expect_txn(2, 1'b0, 1'b0);
    expect_txn(3, 1'b0, 1'b0);
    expect_txn(0, 1'b0, 1'b0);

    // Fairness: cores 0 and 1 re-request immediately; last served was 0.
    req = 4'b0011;
    for (int k = 0; k < 6; k++) expect_txn((k % 2 == 0) ? 1 : 0, 1'b1, 1'b0);
    req = '0;

    // Early drop: core 3 write, req dropped and inputs changed after grant.
    set_core(3, 1'b1, 1'b1, 8'h47, 8'h5A);
    expect_txn(3, 1'b1, 1'b1);
    check("early_drop_req_low", req[3], 0);
    set_core(0, 1'b1, 1'b0, 8'h47, 8'h00);
    expect_txn(0, 1'b0, 1'b0);
    check("early_drop_committed", rdata, 8'h5A);
    req = '0;

    // Reset during WAIT of a core-2 read: no ack, pointer back to N-1.
    set_core(2, 1'b1, 1'b0, 8'h41, 8'h00);
    @(negedge clk);
    check("abort_gnt_access", gnt, 4'b0100);
    @(negedge clk);
    check("abort_busy_wait", busy, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("abort_wait");
    req = '0;
    model_reset();
    @(negedge clk);
    check("abort_no_ack", ack, 0);
    rst_n = 1'b1;
    req = 4'b1111;
    expect_txn(0, 1'b0, 1'b0);
    req = '0;

    // Reset during ACCESS of a write: strobe drops at once, RAM untouched.
    set_core(1, 1'b1, 1'b1, 8'h42, ~shadow[8'h42]);
    @(negedge clk);
    check("abort_we_high", mem_we, 1);
    rst_n = 1'b0;
    #1;
    check("abort_we_async", mem_we, 0);
    check("abort_gnt_async", gnt, 0);
    req = '0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    set_core(1, 1'b1, 1'b0, 8'h42, 8'h00);
    expect_txn(1, 1'b0, 1'b0);
    req = '0;

    // Randomized phase against the reference model.
    for (int c = 0; c < N; c++) begin
      set_core(c, 1'b0, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));
      wait_cnt[c] = 0;
    end
    for (int it = 0; it < 60; it++) begin
      if (req == '0) req[$urandom_range(0, N-1)] = 1'b1;
      w = predict(req);
      check("fair_bound", 32'(wait_cnt[w] <= N - 1), 1);
      for (int c = 0; c < N; c++) if (req[c] && c != w) wait_cnt[c]++;
      wait_cnt[w] = 0;
      expect_txn(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      // Served core: fresh request or idle. Idle cores may raise a request.
      set_core(w, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rand_addr(),
               8'($urandom_range(0, 255)));
      for (int c = 0; c < N; c++) begin
        if (c != w && !req[c] && $urandom_range(0, 2) == 0)
          set_core(c, 1'b1, 1'($urandom_range(0, 1)), rand_addr(), 8'($urandom_range(0, 255)));
      end
    end
    req = '0;
    @(negedge clk);
    check("final_idle_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
